// File: rtl/vga_pkg.sv
// Shared definitions for the CRT display pipeline: word width of the
// attribute FIFO and the refill-request state encoding.
package vga_pkg;

  localparam int CRT_FIFO_WIDTH = 37;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_FILL = 1'b1
  } req_state_e;

endpackage : vga_pkg

// File: rtl/crt_fifo_ram.sv
// Storage array for the CRT attribute FIFO: one synchronous write port,
// one asynchronous read port. The contents are only meaningful below the
// occupancy tracked by the owning FIFO.
module crt_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset; every entry is written before the level
  // counter lets it be read, so clearing it would only cost flops and fanout.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : crt_fifo_ram

// File: rtl/crt_att_fifo.sv
// CRT-clock FIFO buffering 37-bit attribute/pixel words from display memory.
// Presents a registered head word to the serializer, pops one word per
// serializer load, keeps a hysteresis refill request toward the memory
// arbiter and raises sticky underflow/overflow debug flags.
module crt_att_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = CRT_FIFO_WIDTH,
  parameter int LOW_WM  = 4,
  parameter int HIGH_WM = 12,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic             t_crt_clk,
  input  logic             h_reset_n,
  input  logic             m_wr_en,
  input  logic [WIDTH-1:0] m_wr_data,
  input  logic             c_flush,
  input  logic             c_shift_clk,
  input  logic             c_shift_ld,
  input  logic             c_req_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] m_att_data,
  output logic             m_fifo_req,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [LW-1:0]    fifo_level,
  output logic             fifo_unf,
  output logic             fifo_ovf
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LOW_LVL  = LW'(LOW_WM);
  localparam logic [LW-1:0] HIGH_LVL = LW'(HIGH_WM);

  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW-1:0]    rd_ptr_nxt, wr_ptr_nxt;
  logic [LW-1:0]    level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] ram_rdata;
  logic             pop, push_ok, pop_ok, unf_hit, ovf_hit;
  req_state_e       state, state_nxt;

  // Flush overrides everything; a pop only counts when there is a word to
  // take, and a push into a full FIFO only lands when a pop frees a slot.
  assign pop     = c_shift_clk & c_shift_ld;
  assign pop_ok  = pop & ~c_flush & (fifo_level != '0);
  assign push_ok = m_wr_en & ~c_flush & ((fifo_level != FULL_LVL) | pop);
  assign unf_hit = pop & ~c_flush & (fifo_level == '0);
  assign ovf_hit = m_wr_en & ~pop & ~c_flush & (fifo_level == FULL_LVL);

  // Read port looks at the head slot as it will be after this cycle's pop.
  crt_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (t_crt_clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (m_wr_data),
    .raddr (rd_ptr_nxt),
    .rdata (ram_rdata)
  );

  // Next pointers, occupancy and head word.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    level_nxt  = fifo_level;
    head_nxt   = '0;
    if (c_flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (pop_ok)  rd_ptr_nxt = rd_ptr + AW'(1);
      if (push_ok) wr_ptr_nxt = wr_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_nxt = fifo_level + LW'(1);
        2'b01:   level_nxt = fifo_level - LW'(1);
        default: level_nxt = fifo_level;
      endcase
    end
    // The word written this cycle becomes the head only when it lands in an
    // otherwise empty FIFO; the array cannot show it yet, so bypass it.
    if (level_nxt == '0)                      head_nxt = '0;
    else if (push_ok && level_nxt == LW'(1))  head_nxt = m_wr_data;
    else                                      head_nxt = ram_rdata;
  end

  // Pointers, occupancy, status and the registered head word.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      m_att_data <= '0;
      fifo_unf   <= 1'b0;
      fifo_ovf   <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      fifo_level <= level_nxt;
      fifo_empty <= (level_nxt == '0);
      fifo_full  <= (level_nxt == FULL_LVL);
      m_att_data <= head_nxt;
      // A new error in the same cycle as clr_err keeps the flag set.
      fifo_unf   <= unf_hit | (fifo_unf & ~clr_err);
      fifo_ovf   <= ovf_hit | (fifo_ovf & ~clr_err);
    end
  end

  // Request FSM state register.
  always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
    if (!h_reset_n) state <= REQ_IDLE;
    else            state <= state_nxt;
  end

  // Request FSM next state: hysteresis between the low and high watermarks.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ_IDLE: if (c_req_en && !c_flush && level_nxt <= LOW_LVL) state_nxt = REQ_FILL;
      REQ_FILL: if (c_flush || !c_req_en || level_nxt >= HIGH_LVL) state_nxt = REQ_IDLE;
      default:  state_nxt = REQ_IDLE;
    endcase
  end

  // Request FSM output, decoded straight from the state flop.
  always_comb begin
    m_fifo_req = (state == REQ_FILL);
  end

endmodule : crt_att_fifo

// File: tb/tb_crt_att_fifo.sv
// Scoreboard bench for crt_att_fifo: stimulus queues every accepted word,
// a negedge monitor compares the head word at each serializer pop.
module tb_crt_att_fifo;

  localparam int W = 37;

  logic          clk = 1'b0;
  logic          h_reset_n;
  logic          m_wr_en, c_flush, c_shift_clk, c_shift_ld, c_req_en, clr_err;
  logic [W-1:0]  m_wr_data;
  logic [W-1:0]  m_att_data;
  logic          m_fifo_req, fifo_empty, fifo_full, fifo_unf, fifo_ovf;
  logic [4:0]    fifo_level;

  logic [W-1:0]  exp_q[$];
  int            n_pass = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  crt_att_fifo dut (
    .t_crt_clk   (clk),
    .h_reset_n   (h_reset_n),
    .m_wr_en     (m_wr_en),
    .m_wr_data   (m_wr_data),
    .c_flush     (c_flush),
    .c_shift_clk (c_shift_clk),
    .c_shift_ld  (c_shift_ld),
    .c_req_en    (c_req_en),
    .clr_err     (clr_err),
    .m_att_data  (m_att_data),
    .m_fifo_req  (m_fifo_req),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .fifo_unf    (fifo_unf),
    .fifo_ovf    (fifo_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: at every real pop the presented head must be the oldest queued word.
  always @(negedge clk) begin
    if (h_reset_n && c_shift_clk && c_shift_ld && !c_flush) begin
      if (exp_q.size() > 0) check("pop_data", 64'(m_att_data), 64'(exp_q.pop_front()));
      else                  check("pop_empty_att", 64'(m_att_data), 64'd0);
    end
  end

  // One clock of stimulus, entered and left 1 time unit after a posedge.
  task automatic step(input logic wr, input logic [W-1:0] d, input logic pop,
                      input logic fl, input logic clr);
    logic acc;
    m_wr_en = wr; m_wr_data = d; c_shift_clk = pop; c_shift_ld = pop;
    c_flush = fl; clr_err = clr;
    acc = wr & ~fl & ((exp_q.size() < 16) | pop);
    @(posedge clk);
    if (fl)       exp_q.delete();
    else if (acc) exp_q.push_back(d);
    #1;
    m_wr_en = 1'b0; m_wr_data = '0; c_shift_clk = 1'b0; c_shift_ld = 1'b0;
    c_flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    h_reset_n = 1'b0; m_wr_en = 1'b0; m_wr_data = '0; c_flush = 1'b0;
    c_shift_clk = 1'b0; c_shift_ld = 1'b0; c_req_en = 1'b1; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_att",   64'(m_att_data), 64'd0);
    check("rst_empty", 64'(fifo_empty), 64'd1);
    check("rst_full",  64'(fifo_full),  64'd0);
    check("rst_req",   64'(m_fifo_req), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_flags", 64'({fifo_unf, fifo_ovf}), 64'd0);
    h_reset_n = 1'b1;
    idle();
    check("req_after_rst", 64'(m_fifo_req), 64'd1);

    // Fill 16 words; request drops once level reaches 12
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 37'h1_0000_0000 + W'(i), 1'b0, 1'b0, 1'b0);
      check("fill_level", 64'(fifo_level), 64'(i + 1));
      check("fill_req",   64'(m_fifo_req), 64'((i + 1) < 12));
      if (i == 0) check("fill_bypass", 64'(m_att_data), 64'h1_0000_0000);
    end
    check("fill_full", 64'(fifo_full), 64'd1);

    // Overflow: dropped push, then push+pop while full
    step(1'b1, 37'h1_DEAD_0000, 1'b0, 1'b0, 1'b0);
    check("ovf_flag",  64'(fifo_ovf),   64'd1);
    check("ovf_level", 64'(fifo_level), 64'd16);
    step(1'b1, 37'h1_0000_0010, 1'b1, 1'b0, 1'b0);
    check("fullpp_level", 64'(fifo_level), 64'd16);
    check("fullpp_full",  64'(fifo_full),  64'd1);

    // Drain 16 words in order
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 64'(fifo_empty), 64'd1);
    check("drain_att",   64'(m_att_data), 64'd0);
    check("drain_level", 64'(fifo_level), 64'd0);
    check("drain_req",   64'(m_fifo_req), 64'd1);

    // Underflow and set-beats-clear
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("unf_flag",  64'(fifo_unf),   64'd1);
    check("unf_level", 64'(fifo_level), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("unf_set_wins", 64'(fifo_unf), 64'd1);
    check("ovf_cleared",  64'(fifo_ovf), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("unf_cleared", 64'(fifo_unf), 64'd0);

    // Bypass into empty FIFO, then push+pop while empty
    step(1'b1, 37'h0_DEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("byp_att",   64'(m_att_data), 64'h0_DEAD_BEEF);
    check("byp_level", 64'(fifo_level), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("byp_pop_att", 64'(m_att_data), 64'd0);
    step(1'b1, 37'h0_0000_0055, 1'b1, 1'b0, 1'b0);
    check("emptypp_level", 64'(fifo_level), 64'd1);
    check("emptypp_unf",   64'(fifo_unf),   64'd1);
    check("emptypp_att",   64'(m_att_data), 64'h55);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("emptypp_drain", 64'({fifo_unf, fifo_level}), 64'd0);

    // Request gating by c_req_en
    c_req_en = 1'b0;
    idle();
    check("reqen_low", 64'(m_fifo_req), 64'd0);
    c_req_en = 1'b1;
    idle();
    check("reqen_high", 64'(m_fifo_req), 64'd1);

    // Flush at level 7 with a push and pop; sticky unf survives
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 37'h1_2300_0000 + W'(i), 1'b0, 1'b0, 1'b0);
    check("pre_flush_level", 64'(fifo_level), 64'd7);
    step(1'b1, 37'h1_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    check("flush_level", 64'(fifo_level), 64'd0);
    check("flush_att",   64'(m_att_data), 64'd0);
    check("flush_empty", 64'(fifo_empty), 64'd1);
    check("flush_req",   64'(m_fifo_req), 64'd0);
    check("flush_flags", 64'({fifo_unf, fifo_ovf}), 64'b10);
    idle();
    check("flush_req_next", 64'(m_fifo_req), 64'd1);

    // Pointer wrap: 40 push+pop cycles at level 1
    step(1'b1, 37'h0_0A00_0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) step(1'b1, 37'h0_0A00_0000 + W'(i), 1'b1, 1'b0, 1'b0);
    check("wrap_level", 64'(fifo_level), 64'd1);
    check("wrap_att",   64'(m_att_data), 64'h0A00_0028);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("wrap_empty", 64'(fifo_empty), 64'd1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 37'h0_0B00_0000 + W'(i), 1'b0, 1'b0, 1'b0);
    #2;
    h_reset_n = 1'b0;
    #1;
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_att",   64'(m_att_data), 64'd0);
    check("mid_rst_empty", 64'(fifo_empty), 64'd1);
    check("mid_rst_req",   64'(m_fifo_req), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    h_reset_n = 1'b1;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_crt_att_fifo
